// File: rtl/fetch_pc_sequencer.sv
// fetch_pc_sequencer: owns the architectural fetch PC, issues one instruction
// fetch at a time, steps by 4 and applies decode-resolved redirects.
// Optional feature macro: DELAY_SLOT_EN
//   defined   -> MIPS branch-delay-slot semantics, Flush never asserts.
//   undefined -> redirects squash the in-flight fetch and pulse Flush.
//
// state | meaning
// ------+---------------------------------------------------------------
// BOOT  | post-reset idle cycle, no fetch request
// FETCH | fetch outstanding at Fetch_PC, waiting for IMem_Ready
// STALL | fetched word held while the hazard unit stalls fetch/decode
`timescale 1ns/1ps

module fetch_pc_sequencer #(
  parameter logic [31:0] RESET_VECTOR = 32'hBFC00000
) (
  input  logic        CLOCK,
  input  logic        RESET,
  input  logic        Stall,
  input  logic        Redirect_Valid,
  input  logic [31:0] Redirect_Target,
  input  logic        IMem_Ready,
  output logic        Fetch_Req,
  output logic [31:0] Fetch_PC,
  output logic        Decode_Valid,
  output logic [31:0] Decode_PC_Plus4,
  output logic        Flush,
  output logic        Redirect_Pending
);

  typedef enum logic [1:0] {BOOT, FETCH, STALL} seqState_t;

  seqState_t   state, stateNext;
  logic [31:0] fetchPc, fetchPcNext;
  logic        decodeValid, decodeValidNext;
  logic [31:0] decodePcPlus4, decodePcPlus4Next;
  logic        flushReg, flushNext;
  logic        pending, pendingNext;
  logic [31:0] pendTarget, pendTargetNext;

  logic [31:0] alignedTarget;
  logic [31:0] seqPc;
  logic        active;
  logic        advance;

  assign alignedTarget = Redirect_Target & ~32'd3;
  assign seqPc         = fetchPc + 32'd4;
  assign active        = (state != BOOT);
  assign advance       = ((state == FETCH) && IMem_Ready && !Stall) ||
                         ((state == STALL) && !Stall);

  // State and datapath registers; synchronous reset discards any pending redirect
  always_ff @(posedge CLOCK) begin
    if (RESET) begin
      state         <= BOOT;
      fetchPc       <= RESET_VECTOR;
      decodeValid   <= 1'b0;
      decodePcPlus4 <= 32'd0;
      flushReg      <= 1'b0;
      pending       <= 1'b0;
      pendTarget    <= 32'd0;
    end else begin
      state         <= stateNext;
      fetchPc       <= fetchPcNext;
      decodeValid   <= decodeValidNext;
      decodePcPlus4 <= decodePcPlus4Next;
      flushReg      <= flushNext;
      pending       <= pendingNext;
      pendTarget    <= pendTargetNext;
    end
  end

  // Next-state, next-PC and redirect bookkeeping
  always_comb begin
    stateNext         = state;
    fetchPcNext       = fetchPc;
    decodeValidNext   = 1'b0;
    decodePcPlus4Next = decodePcPlus4;
    flushNext         = 1'b0;
    pendingNext       = pending;
    pendTargetNext    = pendTarget;

    case (state)
      BOOT: begin
        stateNext   = FETCH;
        fetchPcNext = RESET_VECTOR;
      end
      FETCH: if (IMem_Ready && Stall) stateNext = STALL;
      STALL: if (!Stall) stateNext = FETCH;
      default: stateNext = BOOT;
    endcase

`ifdef DELAY_SLOT_EN
    // The advancing fetch is always the delay slot; its successor takes the target.
    if (advance) begin
      decodeValidNext   = 1'b1;
      decodePcPlus4Next = seqPc;
      if (pending) begin
        fetchPcNext = pendTarget;
        pendingNext = 1'b0;
      end else if (Redirect_Valid) begin
        fetchPcNext = alignedTarget;
      end else begin
        fetchPcNext = seqPc;
      end
    end else if (active && Redirect_Valid && !pending) begin
      pendingNext    = 1'b1;
      pendTargetNext = alignedTarget;
    end
`else
    // No delay slot: a redirect drops the in-flight word. Redirects seen during
    // a stall are parked internally (first one wins) until the stall drops.
    if (active && !Stall && (pending || Redirect_Valid)) begin
      fetchPcNext = pending ? pendTarget : alignedTarget;
      flushNext   = 1'b1;
      pendingNext = 1'b0;
    end else if (advance) begin
      decodeValidNext   = 1'b1;
      decodePcPlus4Next = seqPc;
      fetchPcNext       = seqPc;
    end else if (active && Stall && Redirect_Valid && !pending) begin
      pendingNext    = 1'b1;
      pendTargetNext = alignedTarget;
    end
`endif
  end

  assign Fetch_Req       = (state == FETCH);
  assign Fetch_PC        = fetchPc;
  assign Decode_Valid    = decodeValid;
  assign Decode_PC_Plus4 = decodePcPlus4;
  assign Flush           = flushReg;
`ifdef DELAY_SLOT_EN
  assign Redirect_Pending = pending;
`else
  assign Redirect_Pending = 1'b0;
`endif

endmodule

// File: doc/fetch_pc_sequencer.md
# fetch_pc_sequencer

Owns the architectural fetch PC for the MIPS pipeline. Issues one instruction-memory fetch at a time, advances sequentially by 4, and applies control-transfer redirects produced by the next-instruction calculator in decode. Honours MIPS branch-delay-slot semantics and hazard-unit stalls. Sits between decode (redirect source), the hazard unit (stall source) and instruction memory (fetch sink).

## Interface
- RESET_VECTOR, 32'hBFC00000, first fetch address after reset (word aligned).
- CLOCK  in  1  rising-edge clock.
- RESET  in  1  synchronous, active-high reset.
- Stall  in  1  hazard unit holds fetch/decode this cycle.
- Redirect_Valid  in  1  decode resolved a taken branch/jump/jr this cycle.
- Redirect_Target  in  32  destination from the next-instruction calculator (bits [1:0] ignored, forced 0).
- IMem_Ready  in  1  instruction memory completes the outstanding fetch this cycle.
- Fetch_Req  out  1  fetch request to instruction memory.
- Fetch_PC  out  32  address of the outstanding fetch.
- Decode_Valid  out  1  one-cycle pulse: fetched word is valid for decode.
- Decode_PC_Plus4  out  32  PC+4 of the word handed to decode (feeds Instr_PC_Plus4).
- Flush  out  1  squash the word currently in the IF/ID register.
- Redirect_Pending  out  1  a redirect target is latched, awaiting delay-slot completion.

## Operation
- States: BOOT, FETCH, STALL.
- BOOT: entered on RESET. Fetch_Req=0. Next cycle goes to FETCH with Fetch_PC=RESET_VECTOR.
- FETCH: Fetch_Req=1. Advance = IMem_Ready & ~Stall. On advance: Fetch_PC <= next_pc; Decode_Valid pulses next cycle, with Decode_PC_Plus4 = old Fetch_PC+4. IMem_Ready & Stall → STALL (word held, not re-fetched).
- STALL: Fetch_Req=0. When Stall drops → FETCH with Fetch_PC already advanced; Decode_Valid pulses the cycle after Stall drops.
- next_pc = Pending_Target if Redirect_Pending, else Fetch_PC+4 (mod 2^32, wraps 32'hFFFFFFFC → 0).
- Redirect with delay slot: Redirect_Valid latches Redirect_Target and sets Redirect_Pending. The next advancing fetch (the delay slot) completes normally; its successor is Pending_Target; Redirect_Pending clears on that advance.
- Same-cycle Redirect_Valid and advance with nothing pending: the advancing fetch is the delay slot; Fetch_PC <= Redirect_Target directly; Redirect_Pending stays 0.
- Redirect_Valid while Redirect_Pending=1: ignored (first target wins).
- Redirect_Valid while Stall=1: still latched (decode result is stable); application waits for the advance.
- Misaligned target: bits [1:0] cleared silently.

## Timing
- Reset values: Fetch_Req=0, Fetch_PC=RESET_VECTOR, Decode_Valid=0, Decode_PC_Plus4=0, Flush=0, Redirect_Pending=0, state=BOOT.
- All outputs are registered; no combinational path from inputs to outputs.
- First Fetch_Req=1 one cycle after RESET deasserts.
- Sequential throughput: one fetch per cycle with IMem_Ready=1 and Stall=0.
- Fetch latency: Decode_Valid one cycle after the advance cycle.
- RESET mid-fetch or mid-redirect: pending target discarded, state BOOT next cycle, no Decode_Valid.

## Configuration
- DELAY_SLOT_EN defined: delay-slot behaviour as above; Flush is constant 0.
- DELAY_SLOT_EN undefined: no delay slot. Redirect_Valid sets Fetch_PC <= Redirect_Target next cycle, Flush=1 for one cycle, the in-flight fetch is dropped (no Decode_Valid for it). Redirect_Pending is constant 0. Redirect_Valid during Stall is applied when Stall drops.

## Test plan
- Reset then IMem_Ready=1, Stall=0 for 4 cycles → Fetch_PC BFC00000, BFC00004, BFC00008, BFC0000C; Decode_PC_Plus4 BFC00004… one cycle later.
- Redirect_Valid=1, target 00400020, at Fetch_PC=BFC00008 with IMem_Ready=0 for 2 cycles (DELAY_SLOT_EN) → Redirect_Pending=1; after BFC00008 completes, Fetch_PC=00400020, pending clears.
- Same stimulus without DELAY_SLOT_EN → Flush=1 one cycle, Fetch_PC=00400020 next cycle, no Decode_Valid for BFC00008.
- Stall=1 for 3 cycles during FETCH with IMem_Ready=1 → Fetch_PC frozen, Decode_Valid=0; one pulse after Stall drops.
- Second Redirect_Valid (target 00500000) while pending 00400020 → Fetch_PC goes to 00400020.
- RESET_VECTOR=FFFFFFF8, two advances → Fetch_PC FFFFFFFC then 00000000; RESET asserted with pending redirect → Redirect_Pending=0, Fetch_PC=FFFFFFF8.
